// File: rtl/lcd_fetch.sv
// Screen fetch engine: walks the screen base file and font banks, emits one pixel byte per char.
// Optional LCD_FLASH_EN: blanks FLS characters while t_1s is high.
module lcd_fetch #(
  parameter int COLS = 106,
  parameter int ROWS = 8
) (
  input  logic        mck,
  input  logic        rin,
  input  logic [1:0]  clkcnt,
  input  logic        lcdon,
  input  logic        t_1s,
  input  logic [12:0] pb0w,
  input  logic [9:0]  pb1w,
  input  logic [8:0]  pb2w,
  input  logic [10:0] pb3w,
  input  logic [10:0] sbrw,
  output logic [21:0] va,
  input  logic [7:0]  vid_cdo,
  output logic [7:0]  pix_data,
  output logic        pix_hires,
  output logic        pix_grey,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        pix_valid,
  input  logic        pix_ready
);

  // state  | meaning
  // IDLE   | display off or between frames; shadows bases on lcdon
  // RD_CHR | read character code from the screen base file
  // RD_ATR | read attribute byte; null chars are skipped here
  // RD_FNT | read font byte for the current pixel line
  // EMIT   | hold the pixel beat until the shifter accepts it

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {IDLE, RD_CHR, RD_ATR, RD_FNT, EMIT} state_t;

  state_t          state;
  logic            addr_sent;
  logic [21:0]     pb0_base, pb1_base, pb2_base, pb3_base, sbr_base;
  logic [6:0]      col, col_nx;
  logic [2:0]      line, line_nx;
  logic [RW-1:0]   row, row_nx;
  logic [7:0]      code;
  logic [5:0]      attr;

  logic [21:0]     chr_addr, fnt_addr;
  logic [8:0]      code9;
  logic [9:0]      code10;
  logic [7:0]      pixel;
  logic            last_col, last_line, last_row, frame_end, null_chr;

  assign last_col  = (col == 7'(COLS - 1));
  assign last_line = (line == 3'd7);
  assign last_row  = (row == RW'(ROWS - 1));
  assign frame_end = last_col && last_line && last_row;
  assign null_chr  = (vid_cdo[5:4] == 2'b11) && (code == 8'h00);

  assign chr_addr = sbr_base + (22'(row) << 8) + 22'({col, 1'b0});
  assign code9    = {attr[0], code};
  assign code10   = {attr[1:0], code};

  always_comb begin
    fnt_addr = '0;
    if (attr[5]) begin
      if (code10 >= 10'd768)
        fnt_addr = pb3_base + 22'({code10 - 10'd768, 3'b000}) + 22'(line);
      else
        fnt_addr = pb2_base + 22'({code10, 3'b000}) + 22'(line);
    end else begin
      if (code9 >= 9'd448)
        fnt_addr = pb0_base + 22'({code9 - 9'd448, 3'b000}) + 22'(line);
      else
        fnt_addr = pb1_base + 22'({code9, 3'b000}) + 22'(line);
    end
  end

  // Pixel pipeline order matters: mask, underline, reverse, then flash blank.
  always_comb begin
    pixel = vid_cdo;
    if (!attr[5]) pixel[7:6] = 2'b00;
    if (!attr[5] && attr[1] && last_line) pixel = 8'h3F;
    if (attr[4]) pixel = attr[5] ? ~pixel : (pixel ^ 8'h3F);
`ifdef LCD_FLASH_EN
    if (attr[3] && t_1s) pixel = 8'h00;
`endif
  end

`ifndef LCD_FLASH_EN
  logic unused_flash;
  assign unused_flash = t_1s ^ attr[3];
`endif

  always_comb begin
    col_nx  = col + 7'd1;
    line_nx = line;
    row_nx  = row;
    if (last_col) begin
      col_nx  = '0;
      line_nx = line + 3'd1;
      if (last_line) row_nx = last_row ? '0 : row + RW'(1);
    end
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      state     <= IDLE;
      addr_sent <= 1'b0;
      va        <= '0;
      pix_data  <= '0;
      pix_hires <= 1'b0;
      pix_grey  <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      pix_valid <= 1'b0;
      pb0_base  <= '0;
      pb1_base  <= '0;
      pb2_base  <= '0;
      pb3_base  <= '0;
      sbr_base  <= '0;
      col       <= '0;
      line      <= '0;
      row       <= '0;
      code      <= '0;
      attr      <= '0;
    end else if (state == IDLE) begin
      addr_sent <= 1'b0;
      pix_valid <= 1'b0;
      if (lcdon) begin
        pb0_base <= {pb0w, 9'b0};
        pb1_base <= {pb1w, 12'b0};
        pb2_base <= {pb2w, 13'b0};
        pb3_base <= {pb3w, 11'b0};
        sbr_base <= {sbrw, 11'b0};
        col      <= '0;
        line     <= '0;
        row      <= '0;
        state    <= RD_CHR;
      end
    end else if (!lcdon) begin
      // Pending beat is dropped; va keeps its last value.
      state     <= IDLE;
      addr_sent <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      unique case (state)
        RD_CHR: begin
          if (!addr_sent) begin
            if (clkcnt == 2'd2) begin
              va        <= chr_addr;
              addr_sent <= 1'b1;
            end
          end else if (clkcnt == 2'd1) begin
            code      <= vid_cdo;
            addr_sent <= 1'b0;
            state     <= RD_ATR;
          end
        end
        RD_ATR: begin
          if (!addr_sent) begin
            if (clkcnt == 2'd2) begin
              va        <= chr_addr + 22'd1;
              addr_sent <= 1'b1;
            end
          end else if (clkcnt == 2'd1) begin
            attr      <= vid_cdo[5:0];
            addr_sent <= 1'b0;
            if (null_chr) begin
              col   <= col_nx;
              line  <= line_nx;
              row   <= row_nx;
              state <= frame_end ? IDLE : RD_CHR;
            end else begin
              state <= RD_FNT;
            end
          end
        end
        RD_FNT: begin
          if (!addr_sent) begin
            if (clkcnt == 2'd2) begin
              va        <= fnt_addr;
              addr_sent <= 1'b1;
            end
          end else if (clkcnt == 2'd1) begin
            addr_sent <= 1'b0;
            pix_data  <= pixel;
            pix_hires <= attr[5];
            pix_grey  <= attr[2];
            pix_eol   <= last_col;
            pix_eof   <= frame_end;
            pix_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            col       <= col_nx;
            line      <= line_nx;
            row       <= row_nx;
            state     <= frame_end ? IDLE : RD_CHR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
